// File: rtl/mul_bcd_seq_pkg.sv
// Shared types and sizing for the sequential 4x4 multiply + binary-to-BCD sequencer.
// Widths here are fixed by the display path: three BCD digits cover the 8-bit product.
package mul_bcd_pkg;
    localparam int A_W       = 4;
    localparam int P_W       = 2 * A_W;
    localparam int BCD_W     = 12;
    localparam int NUM_DIG   = BCD_W / 4;
    localparam int MUL_ITERS = 4;
    localparam int BCD_ITERS = 8;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        BCD,
        DONE
    } state_t;
endpackage

// File: rtl/mul_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/mul_bcd_seq.sv
// Start/done sequencer: shift-add multiply over 4 cycles, then double-dabble over 8
// cycles, presenting registered product and BCD digits to the seven-segment decoders.
module mul_bcd_seq #(
    parameter int A_W = 4,
    parameter int P_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [A_W-1:0] a,
    input  logic [A_W-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [P_W-1:0] product,
    output logic [3:0]     hundreds,
    output logic [3:0]     tens,
    output logic [3:0]     units
);
    import mul_bcd_pkg::*;

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS - 1);
    localparam logic [CNT_W-1:0] BCD_LAST = CNT_W'(BCD_ITERS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [P_W-1:0]   mcand;
    logic [A_W-1:0]   mplr;
    logic [P_W-1:0]   acc;
    logic [P_W-1:0]   bin;
    logic [BCD_W-1:0] bcd;

    logic [P_W-1:0]   accSum;
    logic [BCD_W-1:0] corr;
    logic [BCD_W-1:0] bcdNext;

    assign accSum = mplr[0] ? acc + mcand : acc;

    // One correction per scratch digit, all applied before the shift in the same step.
    for (genvar g = 0; g < NUM_DIG; g++) begin : gDig
        bcd_add3 uAdd3 (
            .din (bcd[g*4 +: 4]),
            .dout(corr[g*4 +: 4])
        );
    end

    assign bcdNext = {corr[BCD_W-2:0], bin[P_W-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mcand    <= '0;
            mplr     <= '0;
            acc      <= '0;
            bin      <= '0;
            bcd      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            hundreds <= '0;
            tens     <= '0;
            units    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= {{(P_W-A_W){1'b0}}, a};
                        mplr  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc   <= accSum;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == MUL_LAST) begin
                        bin   <= accSum;
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= BCD;
                    end
                end
                BCD: begin
                    bcd <= bcdNext;
                    bin <= bin << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == BCD_LAST) begin
                        product  <= acc;
                        hundreds <= bcdNext[11:8];
                        tens     <= bcdNext[7:4];
                        units    <= bcdNext[3:0];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_bcd_seq.sv
// Directed table plus corner sequences and a full operand sweep for mul_bcd_seq.
module tb_mul_bcd_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       busy, done;
    logic [7:0] product;
    logic [3:0] hundreds, tens, units;

    int nChecks = 0;
    int nFail   = 0;

    mul_bcd_seq #(.A_W(4), .P_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .hundreds(hundreds), .tens(tens), .units(units)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a, b;
        int         prod, h, t, u;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one accept edge, then wait for done; lat = -1 on timeout.
    task automatic runOp(input logic [3:0] ia, input logic [3:0] ib,
                         output int lat, output int busyCnt, output int overlap);
        a = ia; b = ib; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1; overlap = 0;
        busyCnt = busy ? 1 : 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (busy && done) overlap = 1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busyCnt++;
        end
        tick();
    endtask

    task automatic checkResult(input string tag, input int prod, input int h,
                               input int t, input int u);
        check({tag, ".product"},  int'(product),  prod);
        check({tag, ".hundreds"}, int'(hundreds), h);
        check({tag, ".tens"},     int'(tens),     t);
        check({tag, ".units"},    int'(units),    u);
    endtask

    initial begin
        vec_t vecs[6];
        int   lat, busyCnt, overlap, dones, k2;

        vecs[0] = '{4'd15, 4'd15, 225, 2, 2, 5};
        vecs[1] = '{4'd0,  4'd9,  0,   0, 0, 0};
        vecs[2] = '{4'd1,  4'd1,  1,   0, 0, 1};
        vecs[3] = '{4'd10, 4'd10, 100, 1, 0, 0};
        vecs[4] = '{4'd15, 4'd7,  105, 1, 0, 5};
        vecs[5] = '{4'd8,  4'd8,  64,  0, 6, 4};

        tick(); tick();
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        checkResult("reset", 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            runOp(vecs[i].a, vecs[i].b, lat, busyCnt, overlap);
            check($sformatf("vec%0d.latency", i), lat, 12);
            check($sformatf("vec%0d.busyCycles", i), busyCnt, 12);
            check($sformatf("vec%0d.busyDoneOverlap", i), overlap, 0);
            checkResult($sformatf("vec%0d", i), vecs[i].prod, vecs[i].h, vecs[i].t, vecs[i].u);
        end

        // start held high: back-to-back accepts every 14 cycles, operands retimed mid-run.
        a = 4'd7; b = 4'd6; start = 1'b1;
        tick();
        a = 4'd9; b = 4'd1;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (done) begin lat = k; break; end
        end
        check("held.latency1", lat, 12);
        checkResult("held1", 42, 0, 4, 2);
        k2 = -1;
        for (int k = lat + 1; k <= 40; k++) begin
            tick();
            if (busy) begin k2 = k; break; end
        end
        check("held.reaccept", k2, 14);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (done) begin lat = k; break; end
        end
        check("held.latency2", lat, 12);
        checkResult("held2", 9, 0, 0, 9);
        tick(); tick();

        // Start and operand noise during MUL and BCD must not disturb a 12*10 run.
        a = 4'd12; b = 4'd10; start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 24; k++) begin
            if (k == 2 || k == 7) begin a = 4'd3; b = 4'd3; start = 1'b1; end
            else start = 1'b0;
            tick();
            if (done) dones++;
        end
        start = 1'b0;
        check("noise.donePulses", dones, 1);
        checkResult("noise", 120, 1, 2, 0);

        // Reset in the middle of a 13*13 run abandons it silently.
        a = 4'd13; b = 4'd13; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midReset.busy", int'(busy), 0);
        check("midReset.done", int'(done), 0);
        checkResult("midReset", 0, 0, 0, 0);
        dones = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (done || busy) dones++;
        end
        check("midReset.quiet", dones, 0);
        runOp(4'd13, 4'd13, lat, busyCnt, overlap);
        check("fresh.latency", lat, 12);
        checkResult("fresh", 169, 1, 6, 9);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                int p;
                p = i * j;
                runOp(4'(i), 4'(j), lat, busyCnt, overlap);
                check($sformatf("sweep%0dx%0d.latency", i, j), lat, 12);
                checkResult($sformatf("sweep%0dx%0d", i, j), p, p / 100, (p / 10) % 10, p % 10);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/mul_bcd_seq.md
# mul_bcd_seq

Sequential controller that replaces the combinational 4x4 multiply and binary-to-BCD stages with a start/done-handshaked, multi-cycle sequencer. It accepts two 4-bit operands, runs a shift-add multiply over 4 cycles, then converts the 8-bit product to three BCD digits by double-dabble over 8 cycles. It presents stable product and digit registers to the existing seven-segment decoders. It sits between operand sources (switches or an upstream controller) and the three display digits.

## Interface
- `A_W`, default 4: operand width. Fixed; the other widths are derived from it.
- `P_W`, default 8: product width, 2*A_W.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request to begin an operation. Sampled only in IDLE.
- `a` in 4: multiplicand, captured on the accepting edge.
- `b` in 4: multiplier, captured on the accepting edge.
- `busy` out 1: high in the MUL and BCD states.
- `done` out 1: high for exactly one cycle, in the DONE state.
- `product` out 8: registered a*b.
- `hundreds` out 4, `tens` out 4, `units` out 4: registered BCD digits of the product.

## Operation
- States: IDLE, MUL, BCD, DONE. One 3-bit iteration counter `cnt` is shared by MUL and BCD.
- IDLE, start=1: latch `mcand` = {4'b0,a} (8-bit), `mplr` = b, `acc` = 0, `cnt` = 0; go to MUL. With start=0, stay in IDLE.
- MUL, each edge:
  - if mplr[0]=1, acc <= acc + mcand (8-bit add, cannot overflow since 15*15=225);
  - mcand <<= 1; mplr >>= 1; cnt++.
  - After the edge where cnt=3: load `bin` = acc (final sum included), clear `bcd` (12-bit scratch), cnt = 0, go to BCD.
- BCD, each edge:
  - apply add-3 to every scratch nibble that is >=5;
  - then shift {bcd,bin} left 1; cnt++.
  - After the edge where cnt=7: go to DONE. On the same edge, load the output registers: `product` <= acc; hundreds, tens, units <= corrected-and-shifted bcd[11:8], [7:4], [3:0].
- DONE: done=1, busy=0. Go to IDLE on the next edge unconditionally. start is ignored in DONE.
- start in MUL, BCD or DONE is ignored. There is no queueing. Operand changes after the accepting edge have no effect.
- Output registers hold their value until the next DONE entry or reset.
- rst=1 at any edge, including mid-operation: state to IDLE, all outputs 0, the operation is abandoned, and no done pulse is produced.

## Timing
- Accepting edge E0 (IDLE, start=1). MUL occupies edges E1–E4, BCD occupies E5–E12, and outputs update at E12.
- done is high in the cycle after E12, which is 12 clocks after E0. The return to IDLE happens at E13.
- Minimum start-to-start period with start held high: 14 cycles. The next accept is E14.
- busy rises after E0 and falls after E12. busy and done are never high together.
- All outputs are registered, with no combinational path from the inputs.

## Structure
- Package `mul_bcd_pkg`: state enum (IDLE, MUL, BCD, DONE), `MUL_ITERS`=4, `BCD_ITERS`=8, `A_W`, `P_W`, `BCD_W`=12.
- One natural sub-module, `bcd_add3`: a combinational 4-bit in / 4-bit out correction (add 3 if the input is >=5). It is instantiated three times in the BCD step.
- The downstream seven-segment decoders are unchanged and driven directly by hundreds, tens and units.

## Test plan
- a=15, b=15, single start pulse: done 12 cycles after the accept, product=225, digits 2/2/5; busy high for exactly 12 cycles.
- a=0, b=9: product=0, digits 0/0/0; done still arrives at exactly 12 cycles.
- a=7, b=6, then a=9, b=1 with start held high throughout: first result 42 (0/4/2), second accept exactly 14 cycles after the first, result 9 (0/0/9).
- start pulsed and a/b changed during MUL and during BCD of a 12*10 run: result stays 120 (1/2/0), and only one done pulse occurs.
- rst asserted on the 6th cycle of a 13*13 run: next cycle outputs are all 0, busy=0, and no done pulse. A fresh 13*13 then yields 169 (1/6/9).
- Exhaustive sweep of all 256 a/b pairs: every product and digit triple matches the reference a*b and its decimal digits.
